mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage data-memory access controller for the five-stage core. It takes the MEM-stage load/store (address from the ALU result, store data already resolved by the forwarding logic) and runs a req/ack handshake with a variable-latency data memory. It stalls the pipeline while the access is outstanding, then returns lane-aligned, sign/zero-extended load data for writeback. Misaligned or illegal accesses are rejected with a fault pulse and issue no memory request.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of dmem_addr

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset: asynchronous, active-high; clears all state immediately
- MEM_valid  in  1  MEM-stage instruction valid (not bubble/flushed)
- MEM_MemRead  in  1  instruction is a load
- MEM_MemWrite  in  1  instruction is a store
- MEM_funct3  in  3  RV32I width/sign code
- MEM_addr  in  ADDR_W  effective byte address (ALU result)
- MEM_store_data  in  32  rs2 value after MEM-stage forwarding
- mem_stall  out  1  hold PC/IF/ID/EX/MEM registers and bubble WB
- mem_fault  out  1  one-cycle misaligned/illegal-access flag
- MEM_load_data  out  32  extended load result, valid when load_valid
- load_valid  out  1  load data valid this cycle
- dmem_req  out  1  memory request, held until dmem_ack
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address (addr[1:0]=0)
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables (writes); 4'hF on reads
- dmem_ack  in  1  memory completes the request this cycle
- dmem_rdata  in  32  read word, valid with dmem_ack

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: access = MEM_valid & (MemRead ^ MemWrite). If access is legal, register dmem_addr/we/wdata/be, set dmem_req=1 and go to WAIT; mem_stall=1 combinationally in this cycle. If access is illegal, mem_fault=1 for this cycle, with no request, no stall, and the state stays IDLE.
- Illegal: MemRead & MemWrite both high; load funct3 ∈ {3,6,7}; store funct3 ≥ 3; halfword with addr[0]=1; word with addr[1:0]≠0.
- WAIT: mem_stall=1 and dmem_req held, with all dmem_* outputs stable. On dmem_ack: drop dmem_req, capture the extracted load data if it is a read, then go to DONE.
- DONE: mem_stall=0. load_valid=1 for loads. Go to IDLE next cycle, so the pipeline advances exactly once.
- Store lanes: SB gives wdata={4{b}} and be=4'b0001<<addr[1:0]. SH gives wdata={2{h}} and be=4'b0011<<{addr[1],1'b0}. SW gives wdata=data and be=4'hF.
- Load extract: select the byte/half by addr[1:0] (latched at issue). LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- dmem_ack in IDLE or DONE is ignored.

## Timing
- Reset values: state=IDLE. dmem_req, dmem_we, mem_stall, mem_fault and load_valid are 0. dmem_addr, dmem_wdata, dmem_be and MEM_load_data are 0.
- Minimum access takes 3 cycles: C0 IDLE/issue (stall=1), C1 WAIT with ack (stall=1), C2 DONE (stall=0, load_valid=1). Each extra memory wait cycle adds one stall cycle.
- The request is registered: dmem_req first rises the cycle after MEM presents the access.
- MEM_load_data holds its last value until the next load completes.
- mem_stall and mem_fault are combinational from state plus MEM_* inputs. All other outputs are registered.
- rst asserted mid-WAIT: dmem_req drops immediately and the FSM goes to IDLE. A late ack after reset is ignored.

## Structure
- Shared package mem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state encoding.
- Sub-module mem_load_align: combinational word + addr[1:0] + funct3 → 32-bit extended result. It is reused by any future load path.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, ack after 2 wait cycles → dmem_addr 0x100, be 4'hF, we=1, stall high 3 cycles, no load_valid.
- SB addr 0x103, data 0x000000A5, ack immediately → be 4'b1000, wdata 0xA5A5A5A5, stall 2 cycles.
- LB addr 0x102, rdata 0x0080FF00 → MEM_load_data 0xFFFFFF80. LBU on the same input → 0x00000080.
- LH addr 0x101 → mem_fault=1 for 1 cycle, dmem_req stays 0, mem_stall 0. LW addr 0x0102 → same response.
- LW issued, rst pulsed in WAIT, ack arrives afterward → all outputs return to reset values, no load_valid, FSM in IDLE.
- Back-to-back LW 0x200 then SW 0x204, ack immediately → two distinct requests separated by the DONE cycle, and the first load is never re-issued.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: RV32I load/store width codes and FSM encoding.
// No logic; imported by mem_access_unit and mem_load_align.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mem_load_align.sv
// Load lane extractor: picks byte/half/word by addr_lo and sign/zero-extends per funct3.
// Purely combinational, zero latency, no backpressure.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b = word[7:0];
    case (addr_lo)
      2'd0: sel_b = word[7:0];
      2'd1: sel_b = word[15:8];
      2'd2: sel_b = word[23:16];
      2'd3: sel_b = word[31:24];
      default: sel_b = word[7:0];
    endcase
    sel_h = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = word;
    case (funct3)
      F3_B:    result = {{24{sel_b[7]}}, sel_b};
      F3_BU:   result = {24'd0, sel_b};
      F3_H:    result = {{16{sel_h[15]}}, sel_h};
      F3_HU:   result = {16'd0, sel_h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: issues one registered req/ack access, stalls the pipe until done.
// Min 3 cycles (issue, ack, done); each memory wait cycle adds one stall; illegal accesses fault without a request.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_valid,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic [2:0]        MEM_funct3,
  input  logic [ADDR_W-1:0] MEM_addr,
  input  logic [31:0]       MEM_store_data,
  output logic              mem_stall,
  output logic              mem_fault,
  output logic [31:0]       MEM_load_data,
  output logic              load_valid,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
);

  logic [1:0]  state;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;
  logic        is_rd, is_wr, is_both;
  logic        misalign, bad_rd, bad_wr;
  logic        issue;
  logic [3:0]  next_be;
  logic [31:0] next_wdata;
  logic [31:0] aligned_data;

  assign is_rd   = MEM_valid & MEM_MemRead & ~MEM_MemWrite;
  assign is_wr   = MEM_valid & MEM_MemWrite & ~MEM_MemRead;
  assign is_both = MEM_valid & MEM_MemRead & MEM_MemWrite;

  // funct3[1:0] is the access size for every legal code, loads and stores alike.
  assign misalign = ((MEM_funct3[1:0] == 2'd1) & MEM_addr[0]) |
                    ((MEM_funct3[1:0] == 2'd2) & (MEM_addr[1:0] != 2'b00));
  assign bad_rd   = (MEM_funct3 == 3'd3) | (MEM_funct3 == 3'd6) | (MEM_funct3 == 3'd7) | misalign;
  assign bad_wr   = (MEM_funct3 >= 3'd3) | misalign;

  assign issue     = (state == ST_IDLE) & ((is_rd & ~bad_rd) | (is_wr & ~bad_wr));
  assign mem_fault = (state == ST_IDLE) & (is_both | (is_rd & bad_rd) | (is_wr & bad_wr));
  assign mem_stall = issue | (state == ST_WAIT);

  always_comb begin
    next_be    = 4'hF;
    next_wdata = MEM_store_data;
    if (is_wr) begin
      case (MEM_funct3[1:0])
        2'd0: begin
          next_be    = 4'b0001 << MEM_addr[1:0];
          next_wdata = {4{MEM_store_data[7:0]}};
        end
        2'd1: begin
          next_be    = 4'b0011 << {MEM_addr[1], 1'b0};
          next_wdata = {2{MEM_store_data[15:0]}};
        end
        default: begin
          next_be    = 4'hF;
          next_wdata = MEM_store_data;
        end
      endcase
    end
  end

  mem_load_align u_align (
    .word    (dmem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .result  (aligned_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_be       <= 4'h0;
      addr_lo_q     <= 2'b00;
      funct3_q      <= 3'd0;
      MEM_load_data <= 32'd0;
      load_valid    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          load_valid <= 1'b0;
          if (issue) begin
            state     <= ST_WAIT;
            dmem_req  <= 1'b1;
            dmem_we   <= is_wr;
            dmem_addr <= {MEM_addr[ADDR_W-1:2], 2'b00};
            dmem_be   <= next_be;
            addr_lo_q <= MEM_addr[1:0];
            funct3_q  <= MEM_funct3;
            if (is_wr) dmem_wdata <= next_wdata;
          end
        end
        ST_WAIT: begin
          if (dmem_ack) begin
            state    <= ST_DONE;
            dmem_req <= 1'b0;
            if (!dmem_we) begin
              MEM_load_data <= aligned_data;
              load_valid    <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          load_valid <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          dmem_req   <= 1'b0;
          load_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset-in-WAIT sequence, random accesses vs a byte-level model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_valid, MEM_MemRead, MEM_MemWrite;
  logic [2:0]  MEM_funct3;
  logic [31:0] MEM_addr, MEM_store_data;
  logic        mem_stall, mem_fault, load_valid;
  logic [31:0] MEM_load_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_load = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .MEM_valid(MEM_valid), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_funct3(MEM_funct3), .MEM_addr(MEM_addr), .MEM_store_data(MEM_store_data),
    .mem_stall(mem_stall), .mem_fault(mem_fault),
    .MEM_load_data(MEM_load_data), .load_valid(load_valid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- reference model, in terms of access size in bytes ----
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr);
    if (rd && wr) return 0;
    if (rd && (f3 == 3 || f3 == 6 || f3 == 7)) return 0;
    if (wr && f3 >= 3) return 0;
    return (addr % nbytes(f3)) == 0;
  endfunction

  function automatic logic [3:0] model_be(input bit wr, input logic [2:0] f3, input logic [31:0] addr);
    longint m;
    if (!wr) return 4'hF;
    m = ((64'd1 << nbytes(f3)) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    longint unsigned v;
    case (nbytes(f3))
      1: v = longint'(d & 32'hFF) * 64'h01010101;
      2: v = longint'(d & 32'hFFFF) * 64'h00010001;
      default: v = longint'(d);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    longint unsigned v, mask;
    int bits;
    bits = 8 * nbytes(f3);
    mask = (64'd1 << bits) - 1;
    v = (longint'(rdata) >> (8 * (addr % 4))) & mask;
    if (f3 < 4 && ((v >> (bits - 1)) & 1) == 1) v = v | ~mask;
    return v[31:0];
  endfunction

  // Presents one MEM-stage access right after a rising edge and walks it to completion.
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input int waits, input logic [31:0] rdata,
                            input bit e_fault, input logic [3:0] e_be,
                            input logic [31:0] e_wdata, input logic [31:0] e_load);
    int stalls;
    stalls = 0;
    MEM_valid = 1'b1; MEM_MemRead = rd; MEM_MemWrite = wr;
    MEM_funct3 = f3; MEM_addr = addr; MEM_store_data = sdata;
    @(negedge clk);
    chk("fault", {31'd0, mem_fault}, {31'd0, e_fault});
    if (e_fault) begin
      chk("fault_stall", {31'd0, mem_stall}, 32'd0);
      @(posedge clk); #1;
      chk("fault_no_req", {31'd0, dmem_req}, 32'd0);
      chk("fault_no_lv", {31'd0, load_valid}, 32'd0);
      MEM_valid = 1'b0;
      return;
    end
    stalls += int'(mem_stall);
    @(posedge clk); #1;
    for (int w = 0; w <= waits; w++) begin
      chk("req_held", {31'd0, dmem_req}, 32'd1);
      chk("dmem_addr", dmem_addr, addr & ~32'd3);
      chk("dmem_be", {28'd0, dmem_be}, {28'd0, e_be});
      chk("dmem_we", {31'd0, dmem_we}, {31'd0, wr});
      if (wr) chk("dmem_wdata", dmem_wdata, e_wdata);
      dmem_ack   = (w == waits);
      dmem_rdata = (w == waits) ? rdata : $urandom;
      @(negedge clk);
      stalls += int'(mem_stall);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
    chk("done_req_low", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    chk("done_stall", {31'd0, mem_stall}, 32'd0);
    chk("stall_cycles", stalls, 2 + waits);
    chk("load_valid", {31'd0, load_valid}, {31'd0, rd});
    if (rd) last_load = e_load;
    chk("load_data", MEM_load_data, last_load);
    @(posedge clk); #1;
    MEM_valid = 1'b0;
    chk("lv_one_cycle", {31'd0, load_valid}, 32'd0);
  endtask

  typedef struct {
    bit          rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, sdata;
    int          waits;
    logic [31:0] rdata;
    bit          e_fault;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_load;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 1, 32'h0,        0, 4'hF,    32'hDEADBEEF, 32'h0};
    vecs[1]  = '{0, 1, 3'd0, 32'h103, 32'h000000A5, 0, 32'h0,        0, 4'b1000, 32'hA5A5A5A5, 32'h0};
    vecs[2]  = '{1, 0, 3'd0, 32'h102, 32'h0,        0, 32'h0080FF00, 0, 4'hF,    32'h0, 32'hFFFFFF80};
    vecs[3]  = '{1, 0, 3'd4, 32'h102, 32'h0,        0, 32'h0080FF00, 0, 4'hF,    32'h0, 32'h00000080};
    vecs[4]  = '{1, 0, 3'd1, 32'h101, 32'h0,        0, 32'h0,        1, 4'hF,    32'h0, 32'h0};
    vecs[5]  = '{1, 0, 3'd2, 32'h102, 32'h0,        0, 32'h0,        1, 4'hF,    32'h0, 32'h0};
    vecs[6]  = '{1, 0, 3'd2, 32'h200, 32'h0,        0, 32'h12345678, 0, 4'hF,    32'h0, 32'h12345678};
    vecs[7]  = '{0, 1, 3'd2, 32'h204, 32'hCAFEF00D, 0, 32'h0,        0, 4'hF,    32'hCAFEF00D, 32'h0};
    vecs[8]  = '{1, 0, 3'd1, 32'h102, 32'h0,        2, 32'h80017FFF, 0, 4'hF,    32'h0, 32'hFFFF8001};
    vecs[9]  = '{1, 0, 3'd5, 32'h102, 32'h0,        0, 32'h80017FFF, 0, 4'hF,    32'h0, 32'h00008001};
    vecs[10] = '{0, 1, 3'd1, 32'h106, 32'h1234BEEF, 0, 32'h0,        0, 4'b1100, 32'hBEEFBEEF, 32'h0};
    vecs[11] = '{1, 1, 3'd2, 32'h300, 32'h0,        0, 32'h0,        1, 4'hF,    32'h0, 32'h0};
    vecs[12] = '{1, 0, 3'd3, 32'h300, 32'h0,        0, 32'h0,        1, 4'hF,    32'h0, 32'h0};
    vecs[13] = '{0, 1, 3'd4, 32'h300, 32'h0,        0, 32'h0,        1, 4'hF,    32'h0, 32'h0};

    rst = 1'b1; MEM_valid = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
    MEM_funct3 = 3'd0; MEM_addr = 32'd0; MEM_store_data = 32'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_fault", {31'd0, mem_fault}, 32'd0);
    chk("rst_lv", {31'd0, load_valid}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_ldata", MEM_load_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Entries 6 and 7 run back to back: LW 0x200 then SW 0x204.
    foreach (vecs[i])
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].sdata,
                 vecs[i].waits, vecs[i].rdata, vecs[i].e_fault, vecs[i].e_be,
                 vecs[i].e_wdata, vecs[i].e_load);

    // Reset while a load is outstanding; the late ack must be ignored.
    MEM_valid = 1'b1; MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0;
    MEM_funct3 = 3'd2; MEM_addr = 32'h400;
    @(posedge clk); #1;
    MEM_valid = 1'b0;
    chk("rw_req_up", {31'd0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rw_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("rw_stall", {31'd0, mem_stall}, 32'd0);
    chk("rw_addr", dmem_addr, 32'd0);
    chk("rw_be", {28'd0, dmem_be}, 32'd0);
    chk("rw_ldata", MEM_load_data, 32'd0);
    last_load = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
    @(negedge clk);
    chk("rw_late_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("rw_late_lv", {31'd0, load_valid}, 32'd0);
    chk("rw_late_req", {31'd0, dmem_req}, 32'd0);
    chk("rw_late_ldata", MEM_load_data, 32'd0);
    @(posedge clk); #1;
    chk("rw_idle_lv", {31'd0, load_valid}, 32'd0);

    // Random traffic, including bubbles with stray acks that must be ignored.
    for (int n = 0; n < 120; n++) begin
      int mode;
      bit rd, wr;
      logic [2:0]  f3;
      logic [31:0] addr, sdata, rdata;
      mode  = $urandom_range(0, 9);
      f3    = 3'($urandom_range(0, 7));
      addr  = 32'h1000 + $urandom_range(0, 63);
      sdata = $urandom;
      rdata = $urandom;
      if (mode == 0) begin
        MEM_valid = $urandom_range(0, 1); MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
        dmem_ack = $urandom_range(0, 1); dmem_rdata = rdata;
        @(negedge clk);
        chk("nop_stall", {31'd0, mem_stall}, 32'd0);
        chk("nop_fault", {31'd0, mem_fault}, 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("nop_req", {31'd0, dmem_req}, 32'd0);
        chk("nop_lv", {31'd0, load_valid}, 32'd0);
        chk("nop_ldata", MEM_load_data, last_load);
        MEM_valid = 1'b0;
      end else begin
        rd = (mode <= 4) || (mode == 9);
        wr = (mode >= 5);
        run_access(rd, wr, f3, addr, sdata, $urandom_range(0, 3), rdata,
                   !model_legal(rd, wr, f3, addr), model_be(wr, f3, addr),
                   model_wdata(f3, sdata), model_load(f3, addr, rdata));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
